// File: rtl/cpu_types_pkg.sv
// Shared types for the dual-core RAM arbiter: RAM handshake states,
// arbiter FSM states and the kind of request that owns the RAM port.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    I  = 2'd0,
    DR = 2'd1,
    DW = 2'd2
  } req_kind_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational requester selection: round-robin between the two cores,
// then write > data read > instruction read within the chosen core.
module rr_picker
  import cpu_types_pkg::*;
(
  input  logic       rr,
  input  logic [1:0] iren,
  input  logic [1:0] dren,
  input  logic [1:0] dwen,
  output logic       valid,
  output logic       owner,
  output req_kind_t  kind
);

  logic [1:0] any;

  assign any = iren | dren | dwen;

  // Core rr wins if it asks at all; a simultaneous dWEN+dREN counts as a write.
  always_comb begin
    valid = |any;
    owner = any[rr] ? rr : ~rr;
    if (dwen[owner])      kind = DW;
    else if (dren[owner]) kind = DR;
    else                  kind = I;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one RAM port between the I/D miss requests of two cores.
// One transfer in flight; the grant is held until RAM reports ACCESS,
// the requester drops its line, or the watchdog expires.
module bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [1:0]              iREN,
  input  logic [1:0]              dREN,
  input  logic [1:0]              dWEN,
  input  logic [1:0][ADDR_W-1:0]  iaddr,
  input  logic [1:0][ADDR_W-1:0]  daddr,
  input  logic [1:0][DATA_W-1:0]  dstore,
  output logic [1:0]              iwait,
  output logic [1:0]              dwait,
  output logic [1:0][DATA_W-1:0]  iload,
  output logic [1:0][DATA_W-1:0]  dload,
  output logic                    ramREN,
  output logic                    ramWEN,
  output logic [ADDR_W-1:0]       ramaddr,
  output logic [DATA_W-1:0]       ramstore,
  input  logic [DATA_W-1:0]       ramload,
  input  logic [1:0]              ramstate,
  output logic                    berr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

  arb_state_t             state;
  logic                   rr;
  logic                   owner;
  req_kind_t              kind;
  logic [CNT_W-1:0]       cnt;
  logic [1:0][DATA_W-1:0] iload_q, dload_q;

  logic      p_vld, p_owner;
  req_kind_t p_kind;
  logic      ack, ack_i, ack_d, line_hi;

  rr_picker u_pick (
    .rr    (rr),
    .iren  (iREN),
    .dren  (dREN),
    .dwen  (dWEN),
    .valid (p_vld),
    .owner (p_owner),
    .kind  (p_kind)
  );

  assign ack   = (state == XFER) && (ramstate_t'(ramstate) == ACCESS);
  assign ack_i = ack && (kind == I);
  assign ack_d = ack && (kind != I);

  // The owner's original request line; dropping it aborts the transfer.
  always_comb begin
    line_hi = dWEN[owner];
    case (kind)
      I:       line_hi = iREN[owner];
      DR:      line_hi = dREN[owner];
      default: line_hi = dWEN[owner];
    endcase
  end

  // Waits follow the request lines except on the owner's ack; loads pass
  // ramload through during the ack and otherwise show the last value.
  always_comb begin
    iwait = iREN;
    dwait = dREN | dWEN;
    iload = iload_q;
    dload = dload_q;
    if (ack_i) begin
      iwait[owner] = 1'b0;
      iload[owner] = ramload;
    end
    if (ack_d) begin
      dwait[owner] = 1'b0;
      dload[owner] = ramload;
    end
  end

  // Arbiter FSM: latch the winner in IDLE, drive RAM from the latches in XFER.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rr       <= 1'b0;
      owner    <= 1'b0;
      kind     <= I;
      cnt      <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      berr     <= 1'b0;
    end else begin
      berr <= 1'b0;
      case (state)
        IDLE: begin
          if (p_vld) begin
            state    <= XFER;
            owner    <= p_owner;
            kind     <= p_kind;
            cnt      <= '0;
            ramaddr  <= (p_kind == I) ? iaddr[p_owner] : daddr[p_owner];
            ramstore <= dstore[p_owner];
            ramREN   <= (p_kind != DW);
            ramWEN   <= (p_kind == DW);
          end
        end
        XFER: begin
          cnt <= cnt + CNT_W'(1);
          if (ack) begin
            state  <= IDLE;
            rr     <= ~owner;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end else if (!line_hi) begin
            // requester gave up: no ack, round-robin pointer untouched
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end else if (cnt == TMAX) begin
            // watchdog: hand priority to the other core so it can progress
            state  <= IDLE;
            rr     <= ~owner;
            berr   <= 1'b1;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered copies of the load data, updated only on the owner's ack.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      if (ack_i) iload_q[owner] <= ramload;
      if (ack_d) dload_q[owner] <= ramload;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a table of single grants walking the priority and
// round-robin rules, then hand sequences for wait states, back-to-back
// requests, fairness, watchdog, requester abort and async reset.
module tb_bus_arbiter;
  import cpu_types_pkg::*;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [1:0]        iREN, dREN, dWEN;
  logic [1:0][31:0]  iaddr, daddr, dstore, iload, dload;
  logic [1:0]        iwait, dwait;
  logic              ramREN, ramWEN, berr;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;

  // RAM model: zero-wait mode acks any enabled cycle; otherwise state is manual.
  logic        zw, model_ld;
  logic [1:0]  rs_man;
  word_t       ld_man;

  function automatic word_t fmem(input word_t a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign ramstate = zw ? ((ramREN | ramWEN) ? 2'd2 : 2'd0) : rs_man;
  assign ramload  = model_ld ? fmem(ramaddr) : ld_man;

  always #5 CLK = ~CLK;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(1023)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .berr(berr)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard of expected acks, popped when the DUT completes a transfer.
  typedef struct {
    logic      owner;
    req_kind_t kind;
    word_t     data;
  } exp_t;
  exp_t sbq[$];

  task automatic push_exp(input logic o, input req_kind_t k, input word_t d);
    exp_t e;
    e.owner = o; e.kind = k; e.data = d;
    sbq.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge CLK) begin
    if (nRST && (ramREN || ramWEN) && ramstate == 2'd2) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected_ack: got ack at addr 0x%0h, expected none", ramaddr);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_load", (mon_e.kind == I) ? iload[mon_e.owner] : dload[mon_e.owner], mon_e.data);
        chk("sb_wait", (mon_e.kind == I) ? iwait[mon_e.owner] : dwait[mon_e.owner], 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  typedef struct {
    logic [1:0] ir, dr, dw;
    logic       o;
    req_kind_t  k;
  } vec_t;
  vec_t vt[10];

  word_t      va;
  logic [1:0] eiw, edw;
  int         early;

  initial begin
    // expected owner/kind traced by hand from rr=0 after reset, rr <= ~owner per ack
    vt[0] = '{2'b01, 2'b00, 2'b00, 1'b0, I};
    vt[1] = '{2'b01, 2'b00, 2'b00, 1'b0, I};
    vt[2] = '{2'b11, 2'b00, 2'b00, 1'b1, I};
    vt[3] = '{2'b10, 2'b01, 2'b00, 1'b0, DR};
    vt[4] = '{2'b00, 2'b11, 2'b10, 1'b1, DW};
    vt[5] = '{2'b01, 2'b01, 2'b01, 1'b0, DW};
    vt[6] = '{2'b01, 2'b01, 2'b00, 1'b0, DR};
    vt[7] = '{2'b10, 2'b00, 2'b00, 1'b1, I};
    vt[8] = '{2'b01, 2'b10, 2'b00, 1'b0, I};
    vt[9] = '{2'b10, 2'b00, 2'b10, 1'b1, DW};

    nRST = 1'b0; zw = 1'b0; model_ld = 1'b1; rs_man = 2'd0; ld_man = '0;
    iREN = 2'b01; dREN = '0; dWEN = '0;
    iaddr[0] = 32'h1000; iaddr[1] = 32'h1100;
    daddr[0] = 32'h2000; daddr[1] = 32'h2100;
    dstore[0] = 32'hC0DE_0000; dstore[1] = 32'hC0DE_0001;

    // reset state
    #12;
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_berr", berr, 1'b0);
    chk("rst_iwait", iwait, 2'b01);
    chk("rst_dwait", dwait, 2'b00);
    iREN = '0;
    @(posedge CLK); #2;
    nRST = 1'b1;
    zw = 1'b1;

    // table: one grant per vector with a zero-wait RAM
    for (int i = 0; i < 10; i++) begin
      iREN = vt[i].ir; dREN = vt[i].dr; dWEN = vt[i].dw;
      va  = (vt[i].k == I) ? iaddr[vt[i].o] : daddr[vt[i].o];
      eiw = vt[i].ir & ~((vt[i].k == I) ? (2'b01 << vt[i].o) : 2'b00);
      edw = (vt[i].dr | vt[i].dw) & ~((vt[i].k != I) ? (2'b01 << vt[i].o) : 2'b00);
      push_exp(vt[i].o, vt[i].k, fmem(va));
      tick();
      chk($sformatf("vec%0d_ren", i), ramREN, vt[i].k != DW);
      chk($sformatf("vec%0d_wen", i), ramWEN, vt[i].k == DW);
      chk($sformatf("vec%0d_addr", i), ramaddr, va);
      chk($sformatf("vec%0d_iwait", i), iwait, eiw);
      chk($sformatf("vec%0d_dwait", i), dwait, edw);
      if (vt[i].k == DW) chk($sformatf("vec%0d_store", i), ramstore, dstore[vt[i].o]);
      tick();
    end
    iREN = '0; dREN = '0; dWEN = '0;

    // instruction read, ACCESS on the second XFER cycle
    zw = 1'b0; model_ld = 1'b0; ld_man = 32'h8C01_0004; rs_man = 2'd1;
    iaddr[0] = 32'h100; iREN = 2'b01;
    push_exp(1'b0, I, 32'h8C01_0004);
    tick();
    chk("s1_ren1", ramREN, 1'b1);
    chk("s1_addr1", ramaddr, 32'h100);
    chk("s1_iwait_busy", iwait, 2'b01);
    tick();
    rs_man = 2'd2;
    #1;
    chk("s1_ren2", ramREN, 1'b1);
    chk("s1_iwait_ack", iwait, 2'b00);
    chk("s1_iload_ack", iload[0], 32'h8C01_0004);
    tick();
    iREN = '0; rs_man = 2'd0; ld_man = '0;
    #1;
    chk("s1_idle_ren", ramREN, 1'b0);
    chk("s1_iload_hold", iload[0], 32'h8C01_0004);

    // write and instruction read together: write first, one IDLE gap, then read
    zw = 1'b1; model_ld = 1'b1;
    daddr[0] = 32'h200; dstore[0] = 32'hDEAD_BEEF;
    iREN = 2'b01; dWEN = 2'b01;
    push_exp(1'b0, DW, fmem(32'h200));
    push_exp(1'b0, I, fmem(32'h100));
    tick();
    chk("s2_wen", ramWEN, 1'b1);
    chk("s2_ren_off", ramREN, 1'b0);
    chk("s2_store", ramstore, 32'hDEAD_BEEF);
    chk("s2_addr_w", ramaddr, 32'h200);
    chk("s2_iwait_held", iwait, 2'b01);
    tick();
    dWEN = '0;
    #1;
    chk("s2_gap_en", {ramREN, ramWEN}, 2'b00);
    tick();
    chk("s2_ren", ramREN, 1'b1);
    chk("s2_addr_r", ramaddr, 32'h100);
    tick();
    iREN = '0;

    // async reset in the middle of a write
    zw = 1'b0; rs_man = 2'd1; dWEN = 2'b01;
    tick();
    chk("s6_wen_before", ramWEN, 1'b1);
    nRST = 1'b0;
    #1;
    chk("s6_wen_async", ramWEN, 1'b0);
    chk("s6_addr_rst", ramaddr, 32'h0);
    chk("s6_berr", berr, 1'b0);
    chk("s6_dwait_in_rst", dwait, 2'b01);
    dWEN = '0;
    @(posedge CLK); #2;
    nRST = 1'b1;
    tick();
    chk("s6_idle_after", {ramREN, ramWEN}, 2'b00);

    // both cores stream data reads: grants alternate 0,1,0 from rr=0
    zw = 1'b1; model_ld = 1'b1;
    daddr[0] = 32'h300; daddr[1] = 32'h304; dREN = 2'b11;
    push_exp(1'b0, DR, fmem(32'h300));
    push_exp(1'b1, DR, fmem(32'h304));
    push_exp(1'b0, DR, fmem(32'h300));
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk($sformatf("s3_ren_k%0d", k), ramREN, 1'b1);
        chk($sformatf("s3_addr_k%0d", k), ramaddr, ((k / 2) % 2 == 1) ? 32'h304 : 32'h300);
        chk($sformatf("s3_dwait_k%0d", k), dwait, ((k / 2) % 2 == 1) ? 2'b01 : 2'b10);
      end else begin
        chk($sformatf("s3_gap_k%0d", k), ramREN, 1'b0);
      end
    end

    // core 1 read against a stuck RAM: watchdog fires after TIMEOUT+1 XFER cycles
    dREN = 2'b10; zw = 1'b0; rs_man = 2'd1;
    tick();
    chk("s4_grant_ren", ramREN, 1'b1);
    chk("s4_grant_addr", ramaddr, 32'h304);
    daddr[1] = 32'h400;
    early = 0;
    for (int t = 2; t <= 1024; t++) begin
      tick();
      rs_man = (t >= 500 && t < 510) ? 2'd3 : 2'd1;
      if (berr || !ramREN) early++;
    end
    chk("s4_no_early_abort", early, 0);
    chk("s4_addr_not_resampled", ramaddr, 32'h304);
    tick();
    chk("s4_berr_pulse", berr, 1'b1);
    chk("s4_idle_ren", ramREN, 1'b0);
    chk("s4_dwait_held", dwait, 2'b10);
    dREN = 2'b11;
    tick();
    chk("s4_berr_one_cycle", berr, 1'b0);
    chk("s4_rr_to_core0", ramaddr, 32'h300);

    // core 0 gives up after 3 BUSY cycles; pending core 1 is served next
    tick();
    tick();
    chk("s5_busy3_ren", ramREN, 1'b1);
    dREN = 2'b10;
    tick();
    chk("s5_abort_idle", ramREN, 1'b0);
    chk("s5_abort_dwait", dwait, 2'b10);
    chk("s5_no_ack_load", dload[0], fmem(32'h300));
    tick();
    chk("s5_core1_addr", ramaddr, 32'h400);
    push_exp(1'b1, DR, fmem(32'h400));
    rs_man = 2'd2;
    #1;
    chk("s5_core1_dwait", dwait, 2'b00);
    chk("s5_core1_dload", dload[1], fmem(32'h400));
    tick();
    dREN = '0; rs_man = 2'd0;
    tick();

    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
